// File: rtl/dat_tx_serializer_if.sv
// Host-side bundle for the SD DAT0 transmit serializer: FIFO read port, DAT0 pad
// controls, SD clock gate and the transfer handshake.
interface dat_tx_serializer_if;
    logic        start;
    logic [15:0] block_count;
    logic        fifo_read;
    logic [31:0] data_from_fifo;
    logic        fifo_empty;
    logic        dat_out;
    logic        dat_oe;
    logic        dat_in;
    logic        sd_clk_en;
    logic        TFC;

    modport master (
        output start, block_count, data_from_fifo, fifo_empty, dat_in,
        input  fifo_read, dat_out, dat_oe, sd_clk_en, TFC
    );

    modport slave (
        input  start, block_count, data_from_fifo, fifo_empty, dat_in,
        output fifo_read, dat_out, dat_oe, sd_clk_en, TFC
    );
endinterface

// File: rtl/dat_tx_serializer.sv
// Drains 32-bit FIFO words onto SD DAT0 (1-bit mode) as framed blocks with CRC16,
// waits out card busy, and gates the SD clock whenever the FIFO starves mid-block.
module dat_tx_serializer #(
    parameter int unsigned BLOCK_WORDS = 128,
    parameter int unsigned BUSY_GAP    = 2
) (
    input logic                CLK,
    input logic                RESET,
    dat_tx_serializer_if.slave bus
);
    localparam int unsigned WORD_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam int unsigned GAP_W  = (BUSY_GAP > 0) ? $clog2(BUSY_GAP + 1) : 1;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BLOCK_WORDS - 1);
    localparam logic [GAP_W-1:0]  GAP_END   = GAP_W'(BUSY_GAP);
    localparam logic [15:0]       CRC_POLY  = 16'h1021;

    typedef enum logic [2:0] {
        StIdle, StLoad, StStart, StData, StCrc, StEnd, StBusy, StDone
    } state_e;

    state_e             state_q, state_d;
    logic               start_q;
    logic [31:0]        hr_q, hr_d;
    logic               hr_valid_q, hr_valid_d;
    logic               rd_pend_q, rd_pend_d;
    logic [31:0]        sr_q, sr_d;
    logic [15:0]        crc_q, crc_d, crc_next;
    logic [4:0]         bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]  word_cnt_q, word_cnt_d;
    logic [15:0]        blocks_q, blocks_d;
    logic [GAP_W-1:0]   gap_q, gap_d;

    always_comb begin
        state_d       = state_q;
        hr_d          = hr_q;
        hr_valid_d    = hr_valid_q;
        rd_pend_d     = rd_pend_q;
        sr_d          = sr_q;
        crc_d         = crc_q;
        bit_cnt_d     = bit_cnt_q;
        word_cnt_d    = word_cnt_q;
        blocks_d      = blocks_q;
        gap_d         = gap_q;
        bus.dat_out   = 1'b1;
        bus.dat_oe    = 1'b0;
        bus.sd_clk_en = 1'b0;
        bus.TFC       = 1'b0;
        crc_next      = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ sr_q[31]) ? CRC_POLY : 16'h0000);

        // Single-entry prefetch: one read in flight at most, landing in HR a cycle later.
        if (rd_pend_q) begin
            hr_d       = bus.data_from_fifo;
            hr_valid_d = 1'b1;
            rd_pend_d  = 1'b0;
        end
        bus.fifo_read = bus.start && (state_q != StIdle) && (state_q != StDone) &&
                        !hr_valid_q && !rd_pend_q && !bus.fifo_empty;
        if (bus.fifo_read) begin
            rd_pend_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start && !start_q) begin
                    blocks_d = bus.block_count;
                    state_d  = (bus.block_count == 16'd0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                if (hr_valid_q) begin
                    sr_d       = hr_q;
                    hr_valid_d = 1'b0;
                    word_cnt_d = '0;
                    bit_cnt_d  = '0;
                    crc_d      = '0;
                    state_d    = StStart;
                end
            end
            StStart: begin
                bus.dat_oe    = 1'b1;
                bus.dat_out   = 1'b0;
                bus.sd_clk_en = 1'b1;
                state_d       = StData;
            end
            StData: begin
                bus.dat_oe  = 1'b1;
                bus.dat_out = sr_q[31];
                // Last bit of a word waits for the next word so the card never sees a gap.
                if (!(bit_cnt_q == 5'd31 && word_cnt_q != LAST_WORD && !hr_valid_q)) begin
                    bus.sd_clk_en = 1'b1;
                    crc_d         = crc_next;
                    bit_cnt_d     = bit_cnt_q + 5'd1;
                    if (bit_cnt_q != 5'd31) begin
                        sr_d = {sr_q[30:0], 1'b0};
                    end else if (word_cnt_q == LAST_WORD) begin
                        state_d = StCrc;
                    end else begin
                        sr_d       = hr_q;
                        hr_valid_d = 1'b0;
                        word_cnt_d = word_cnt_q + 1'b1;
                    end
                end
            end
            StCrc: begin
                bus.dat_oe    = 1'b1;
                bus.sd_clk_en = 1'b1;
                bus.dat_out   = crc_q[15];
                crc_d         = {crc_q[14:0], 1'b0};
                bit_cnt_d     = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd15) begin
                    bit_cnt_d = '0;
                    state_d   = StEnd;
                end
            end
            StEnd: begin
                bus.dat_oe    = 1'b1;
                bus.sd_clk_en = 1'b1;
                blocks_d      = blocks_q - 16'd1;
                gap_d         = '0;
                state_d       = StBusy;
            end
            StBusy: begin
                bus.sd_clk_en = 1'b1;
                if (gap_q != GAP_END) begin
                    gap_d = gap_q + 1'b1;
                end else if (bus.dat_in) begin
                    state_d = (blocks_q == 16'd0) ? StDone : StLoad;
                end
            end
            StDone: begin
                bus.TFC = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Dropping start aborts anywhere; an in-flight FIFO word is discarded.
        if (state_q != StIdle && !bus.start) begin
            state_d    = StIdle;
            hr_valid_d = 1'b0;
            rd_pend_d  = 1'b0;
            bus.TFC    = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            hr_q       <= '0;
            hr_valid_q <= 1'b0;
            rd_pend_q  <= 1'b0;
            sr_q       <= '0;
            crc_q      <= '0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            blocks_q   <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= bus.start;
            hr_q       <= hr_d;
            hr_valid_q <= hr_valid_d;
            rd_pend_q  <= rd_pend_d;
            sr_q       <= sr_d;
            crc_q      <= crc_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            blocks_q   <= blocks_d;
            gap_q      <= gap_d;
        end
    end
endmodule

// File: tb/tb_dat_tx_serializer.sv
// Directed-plus-random bench for dat_tx_serializer: a queue FIFO feeds the DUT and
// every DAT0 frame is compared to one built from the words with CRC by polynomial division.
module tb_dat_tx_serializer;
    localparam int BW    = 128;
    localparam int GAP   = 2;
    localparam int FRAME = 1 + 32 * BW + 16 + 1;

    logic CLK = 1'b0;
    logic RESET;

    dat_tx_serializer_if bus ();

    dat_tx_serializer #(
        .BLOCK_WORDS(BW),
        .BUSY_GAP   (GAP)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    logic [31:0] fq[$];
    logic [31:0] wq[$];
    logic        cap[$];
    logic        exp_bits[$];
    int total = 0, bad = 0, cyc = 0;
    int n_reads = 0, n_tfc = 0, n_stall = 0, n_hold_bad = 0, n_oe = 0, tfc_cyc = 0;
    logic prev_stall = 1'b0, prev_dat = 1'b1;

    // FIFO model: a read strobe pops a word that is presented the next cycle.
    always @(posedge CLK) begin
        cyc++;
        if (bus.fifo_read === 1'b1) begin
            n_reads++;
            if (fq.size() > 0) bus.data_from_fifo <= fq.pop_front();
        end
    end

    always @(negedge CLK) begin
        bus.fifo_empty = (fq.size() == 0);
        if (bus.sd_clk_en === 1'b1 && bus.dat_oe === 1'b1) cap.push_back(bus.dat_out);
        if (bus.dat_oe === 1'b1 && bus.sd_clk_en === 1'b0) begin
            n_stall++;
            if (prev_stall && bus.dat_out !== prev_dat) n_hold_bad++;
        end
        prev_stall = (bus.dat_oe === 1'b1 && bus.sd_clk_en === 1'b0);
        prev_dat   = bus.dat_out;
        if (bus.TFC === 1'b1) begin
            n_tfc++;
            tfc_cyc = cyc;
        end
        if (bus.dat_oe === 1'b1) n_oe++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Frame = start bit, data MSB first, remainder of M(x)*x^16 / G(x), end bit.
    task automatic model_block(input int blk, output logic [15:0] crc);
        bit          m[];
        logic [16:0] g;
        int          n;
        g = 17'h11021;
        n = 32 * BW;
        m = new[n + 16];
        for (int i = 0; i < n; i++) m[i] = wq[blk * BW + i / 32][31 - i % 32];
        exp_bits.push_back(1'b0);
        for (int i = 0; i < n; i++) exp_bits.push_back(m[i]);
        for (int i = 0; i < n; i++) begin
            if (m[i]) for (int j = 0; j <= 16; j++) m[i + j] ^= g[16 - j];
        end
        crc = '0;
        for (int j = 0; j < 16; j++) crc[15 - j] = m[n + j];
        for (int j = 0; j < 16; j++) exp_bits.push_back(crc[15 - j]);
        exp_bits.push_back(1'b1);
    endtask

    task automatic cmp_frames(input string tag, input int base);
        int miss;
        miss = 0;
        check({tag, "_len"}, cap.size() - base, exp_bits.size());
        for (int i = 0; i < exp_bits.size(); i++) begin
            if (base + i >= cap.size() || cap[base + i] !== exp_bits[i]) miss++;
        end
        check({tag, "_bits"}, miss, 0);
    endtask

    task automatic wait_tfc(input int n0, input int limit);
        int t;
        t = 0;
        while (n_tfc == n0 && t < limit) begin
            tick(1);
            t++;
        end
    endtask

    task automatic wait_bits(input int base, input int nbits, input int limit);
        int t;
        t = 0;
        while (cap.size() - base < nbits && t < limit) begin
            tick(1);
            t++;
        end
    endtask

    task automatic load_words(input int n, input int mode, input int nfifo);
        wq.delete();
        fq.delete();
        exp_bits.delete();
        for (int i = 0; i < n; i++) begin
            if (mode == 0) wq.push_back(32'hFFFF_FFFF);
            else if (mode == 1) wq.push_back(32'(i + 1));
            else wq.push_back($urandom);
        end
        for (int i = 0; i < nfifo; i++) fq.push_back(wq[i]);
    endtask

    initial begin
        logic [15:0] crc, crc2, cap_crc;
        int base, r0, t0, o0, c0, s0, h0, n1, t, miss;

        RESET           = 1'b1;
        bus.start       = 1'b0;
        bus.block_count = 16'd0;
        bus.dat_in      = 1'b1;
        #2;
        check("rst_dat_oe", bus.dat_oe, 1'b0);
        check("rst_dat_out", bus.dat_out, 1'b1);
        check("rst_fifo_read", bus.fifo_read, 1'b0);
        check("rst_sd_clk_en", bus.sd_clk_en, 1'b0);
        check("rst_tfc", bus.TFC, 1'b0);
        tick(2);
        RESET = 1'b0;
        tick(2);

        // Zero blocks: immediate completion, no DAT drive, no FIFO traffic.
        r0 = n_reads; t0 = n_tfc; o0 = n_oe; c0 = cyc;
        bus.block_count = 16'd0;
        bus.start       = 1'b1;
        tick(5);
        check("bc0_tfc_count", n_tfc - t0, 1);
        check("bc0_tfc_latency", ((tfc_cyc - c0) inside {1, 2}), 1'b1);
        check("bc0_reads", n_reads - r0, 0);
        check("bc0_oe", n_oe - o0, 0);
        bus.start = 1'b0;
        tick(2);

        // One block of all ones.
        load_words(BW, 0, BW);
        model_block(0, crc);
        check("ones_model_crc", crc, 16'h7FA1);
        base = cap.size(); r0 = n_reads; t0 = n_tfc;
        bus.block_count = 16'd1;
        bus.start       = 1'b1;
        wait_tfc(t0, 6000);
        check("ones_tfc", n_tfc - t0, 1);
        cmp_frames("ones", base);
        cap_crc = '0;
        for (int j = 0; j < 16; j++) begin
            if (base + 1 + 32 * BW + j < cap.size()) cap_crc[15 - j] = cap[base + 1 + 32 * BW + j];
        end
        check("ones_dat_crc", cap_crc, 16'h7FA1);
        check("ones_reads", n_reads - r0, BW);
        // start still high after DONE must not relaunch.
        o0 = n_oe;
        tick(20);
        check("held_start_tfc", n_tfc - t0, 1);
        check("held_start_oe", n_oe - o0, 0);
        bus.start = 1'b0;
        tick(2);

        // Two blocks, card holds busy well past the ignore window.
        load_words(2 * BW, 1, 2 * BW);
        model_block(0, crc);
        model_block(1, crc2);
        base = cap.size(); r0 = n_reads; t0 = n_tfc;
        bus.dat_in      = 1'b0;
        bus.block_count = 16'd2;
        bus.start       = 1'b1;
        wait_bits(base, FRAME, 6000);
        check("two_blk1_len", cap.size() - base, FRAME);
        n1 = cap.size();
        tick(GAP + 10);
        check("busy_no_start", cap.size(), n1);
        check("busy_oe", bus.dat_oe, 1'b0);
        check("busy_clk", bus.sd_clk_en, 1'b1);
        bus.dat_in = 1'b1;
        wait_tfc(t0, 6000);
        check("two_tfc", n_tfc - t0, 1);
        cmp_frames("two", base);
        check("two_reads", n_reads - r0, 2 * BW);
        bus.start = 1'b0;
        tick(2);

        // FIFO starves after word 5; refill timed for a 7-cycle clock gap.
        load_words(BW, 2, 6);
        model_block(0, crc);
        base = cap.size(); t0 = n_tfc; s0 = n_stall; h0 = n_hold_bad;
        bus.block_count = 16'd1;
        bus.start       = 1'b1;
        t = 0;
        while (n_stall == s0 && t < 2000) begin
            tick(1);
            t++;
        end
        tick(4);
        for (int i = 6; i < BW; i++) fq.push_back(wq[i]);
        wait_tfc(t0, 6000);
        check("stall_tfc", n_tfc - t0, 1);
        check("stall_cycles", n_stall - s0, 7);
        check("stall_hold", n_hold_bad - h0, 0);
        cmp_frames("stall", base);
        bus.start = 1'b0;
        tick(2);

        // Abort at word 40.
        load_words(BW, 2, BW);
        model_block(0, crc);
        base = cap.size();
        bus.block_count = 16'd1;
        bus.start       = 1'b1;
        wait_bits(base, 1 + 32 * 40, 3000);
        bus.start = 1'b0;
        r0 = n_reads; t0 = n_tfc;
        tick(1);
        check("abort_oe", bus.dat_oe, 1'b0);
        check("abort_clk", bus.sd_clk_en, 1'b0);
        tick(5);
        check("abort_reads", n_reads - r0, 0);
        check("abort_tfc", n_tfc - t0, 0);
        miss = 0;
        for (int i = 0; i < 1 + 32 * 40; i++) begin
            if (base + i >= cap.size() || cap[base + i] !== exp_bits[i]) miss++;
        end
        check("abort_prefix", miss, 0);

        // Asynchronous reset mid-DATA, then a clean block.
        load_words(BW, 2, BW);
        base = cap.size();
        bus.start = 1'b1;
        wait_bits(base, 100, 2000);
        #3;
        RESET = 1'b1;
        #1;
        check("mid_rst_dat_oe", bus.dat_oe, 1'b0);
        check("mid_rst_dat_out", bus.dat_out, 1'b1);
        check("mid_rst_fifo_read", bus.fifo_read, 1'b0);
        check("mid_rst_tfc", bus.TFC, 1'b0);
        check("mid_rst_clk", bus.sd_clk_en, 1'b0);
        bus.start = 1'b0;
        tick(2);
        RESET = 1'b0;
        load_words(BW, 2, BW);
        model_block(0, crc);
        tick(2);
        base = cap.size(); t0 = n_tfc;
        bus.start = 1'b1;
        wait_tfc(t0, 6000);
        check("post_rst_tfc", n_tfc - t0, 1);
        cmp_frames("post_rst", base);
        bus.start = 1'b0;
        tick(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
